// File: rtl/fib_pkg.sv
// ============================================================================
// Module      : fib_pkg
// Description : Shared FSM state type and beat lane-count constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fib_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] c_lanes_one = 2'd1;
  localparam logic [1:0] c_lanes_two = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fib_seq_ctrl_core.sv
// ============================================================================
// Module      : fib_core
// Description : Registered Fibonacci term pair with one/two-term stepping and
//               sticky per-term wrap flags; exposes the next-state values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step1,
  input  logic             i_step2,
  output logic [WIDTH-1:0] o_nxt_t0,
  output logic [WIDTH-1:0] o_nxt_t1,
  output logic             o_nxt_w0,
  output logic             o_nxt_w1
);

  logic [WIDTH-1:0] r_t0, r_t1;
  logic             r_w0, r_w1;
  logic [WIDTH:0]   w_s1, w_s2;
  logic             w_s1_wr, w_s2_wr;

  // A wrap flag marks a term whose true value no longer fits; later terms inherit it.
  always_comb begin
    w_s1     = {1'b0, r_t0} + {1'b0, r_t1};
    w_s2     = {1'b0, r_t1} + {1'b0, w_s1[WIDTH-1:0]};
    w_s1_wr  = r_w0 | r_w1 | w_s1[WIDTH];
    w_s2_wr  = w_s1_wr | w_s2[WIDTH];
    o_nxt_t0 = r_t0;
    o_nxt_t1 = r_t1;
    o_nxt_w0 = r_w0;
    o_nxt_w1 = r_w1;
    if (i_load) begin
      o_nxt_t0 = WIDTH'(1);
      o_nxt_t1 = WIDTH'(1);
      o_nxt_w0 = 1'b0;
      o_nxt_w1 = 1'b0;
    end else if (i_step2) begin
      o_nxt_t0 = w_s1[WIDTH-1:0];
      o_nxt_t1 = w_s2[WIDTH-1:0];
      o_nxt_w0 = w_s1_wr;
      o_nxt_w1 = w_s2_wr;
    end else if (i_step1) begin
      o_nxt_t0 = r_t1;
      o_nxt_t1 = w_s1[WIDTH-1:0];
      o_nxt_w0 = r_w1;
      o_nxt_w1 = w_s1_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t0 <= '0;
      r_t1 <= '0;
      r_w0 <= 1'b0;
      r_w1 <= 1'b0;
    end else begin
      r_t0 <= o_nxt_t0;
      r_t1 <= o_nxt_t1;
      r_w0 <= o_nxt_w0;
      r_w1 <= o_nxt_w1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fib_seq_ctrl.sv
// ============================================================================
// Module      : fib_seq_ctrl
// Description : Job controller streaming Fibonacci terms, one or two per beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic             req_double,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [1:0]       out_lanes,
  output logic             out_last,
  output logic             out_ovf,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic             r_double;
  logic [CNT_W-1:0] r_rem, w_rem_after;
  logic             w_req_hs, w_out_hs, w_accept, w_step, w_done_nxt;
  logic [1:0]       w_first_lanes, w_lanes_nxt;
  logic [WIDTH-1:0] w_nxt_t0, w_nxt_t1;
  logic             w_nxt_w0, w_nxt_w1;

  assign w_req_hs = req_valid && req_ready;
  assign w_out_hs = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_hs) begin
          if (req_count != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        // abort wins over a beat handshake in the same cycle
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_out_hs) begin
          if (out_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_first_lanes = (req_double && req_count >= CNT_W'(2)) ? c_lanes_two : c_lanes_one;
  assign w_rem_after   = r_rem - CNT_W'(out_lanes);
  assign w_lanes_nxt   = (r_double && w_rem_after >= CNT_W'(2)) ? c_lanes_two : c_lanes_one;

  fib_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_step1  (w_step && !r_double),
    .i_step2  (w_step && r_double),
    .o_nxt_t0 (w_nxt_t0),
    .o_nxt_t1 (w_nxt_t1),
    .o_nxt_w0 (w_nxt_w0),
    .o_nxt_w1 (w_nxt_w1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      req_ready <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      req_ready <= (w_state_nxt == IDLE);
      out_valid <= (w_state_nxt == RUN);
      done      <= w_done_nxt;
    end
  end

  // Beat registers only move on job load or an accepted beat, so stalls hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_double  <= 1'b0;
      r_rem     <= '0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_lanes <= 2'd0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_double  <= req_double;
      r_rem     <= req_count;
      out_data0 <= WIDTH'(1);
      out_data1 <= (w_first_lanes == c_lanes_two) ? WIDTH'(1) : '0;
      out_lanes <= w_first_lanes;
      out_last  <= (req_count <= CNT_W'(w_first_lanes));
      out_ovf   <= 1'b0;
    end else if (r_state == RUN && !abort && w_out_hs) begin
      r_rem <= w_rem_after;
      if (!out_last) begin
        out_data0 <= w_nxt_t0;
        out_data1 <= (w_lanes_nxt == c_lanes_two) ? w_nxt_t1 : '0;
        out_lanes <= w_lanes_nxt;
        out_last  <= (w_rem_after <= CNT_W'(w_lanes_nxt));
        out_ovf   <= w_nxt_w0 | ((w_lanes_nxt == c_lanes_two) & w_nxt_w1);
      end
    end
  end

endmodule

`default_nettype wire
